// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// transmit FSM states and the bit-period calculation.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data, occupancy count
// and full/empty flags derived from the count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // No bypass: a full FIFO refuses a push even when a pop happens this cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a transmit FIFO; configurable data bits, parity and
// stop bits, with back-to-back frames whenever words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BAUD == 0 || CLK_HZ < BAUD) begin : g_bad_baud
    $error("uart_tx_fifo: BAUD must be nonzero and not exceed CLK_HZ");
  end

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;

  uart_state_e          w_state_d;
  logic [CNT_W-1:0]     w_cnt_d;
  logic [IDX_W-1:0]     w_bit_idx_d;
  logic                 w_stop_idx_d;
  logic [DATA_BITS-1:0] w_shift_d;
  logic                 w_tx_d;
  logic                 w_tick;
  logic                 w_last_bit;
  logic                 w_last_stop;
  logic                 w_par_bit;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign in_ready    = !w_fifo_full;
  assign busy        = (r_state != StIdle) || (fifo_count != '0);
  assign tx          = r_tx;
  assign w_tick      = (r_cnt == CNT_W'(DIV - 1));
  assign w_last_bit  = (r_bit_idx == IDX_W'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
  assign w_par_bit   = (PARITY == PAR_ODD) ? ~^w_shift_d : ^w_shift_d;

  always_comb begin
    w_state_d    = r_state;
    w_bit_idx_d  = r_bit_idx;
    w_stop_idx_d = r_stop_idx;
    w_shift_d    = r_shift;
    w_pop        = 1'b0;

    // Held at zero while idle so the first bit of a frame gets a full period.
    if (r_state == StIdle || w_tick) w_cnt_d = '0;
    else                             w_cnt_d = r_cnt + CNT_W'(1);

    case (r_state)
      StIdle: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_d   = w_fifo_rdata;
          w_bit_idx_d = '0;
          w_state_d   = StStart;
        end
      end
      StStart: begin
        if (w_tick) w_state_d = StData;
      end
      StData: begin
        if (w_tick) begin
          if (w_last_bit) begin
            w_stop_idx_d = 1'b0;
            w_state_d    = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + IDX_W'(1);
          end
        end
      end
      StParity: begin
        if (w_tick) begin
          w_stop_idx_d = 1'b0;
          w_state_d    = StStop;
        end
      end
      StStop: begin
        if (w_tick) begin
          if (!w_last_stop) begin
            w_stop_idx_d = 1'b1;
          end else if (!w_fifo_empty) begin
            // Chain straight into the next frame without an idle gap.
            w_pop       = 1'b1;
            w_shift_d   = w_fifo_rdata;
            w_bit_idx_d = '0;
            w_state_d   = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level is decided from the state being entered so tx is a clean flop output.
  always_comb begin
    w_tx_d = 1'b1;
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[w_bit_idx_d];
      StParity: w_tx_d = w_par_bit;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_stop_idx <= w_stop_idx_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format (data bits, parity, stop bits) and a ready/valid input handshake. It sits between on-chip producers (keyboard/display controllers, debug logic) and the board's USB-UART TX pin. It replaces single-byte, 8N1-only transmission with back-to-back buffered frames at any baud derived from the system clock.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, TX FIFO entries, power of two, ≥2
- clk  in  1  system clock; reset rst is asynchronous, active-high; clock clk
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  producer offers in_data
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  DATA_BITS  word to send, LSB transmitted first
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words waiting in FIFO

## Operation
- Push: word is written when in_valid && in_ready on a rising clk edge. No bypass, so a full FIFO rejects a push even if a pop happens in the same cycle.
- Bit period DIV = (CLK_HZ + BAUD/2) / BAUD cycles, rounded to nearest. Counter width is $clog2(DIV). Counter counts 0..DIV-1; the tick fires at DIV-1.
- The counter is held at 0 in IDLE and restarts at 0 on every frame start, so every bit, including the start bit, lasts exactly DIV cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop into shift register, clear bit index, go to START. Otherwise stay.
  - START: tx=0. On tick go to DATA.
  - DATA: tx=shift[bit index]. On tick, if index == DATA_BITS-1, go to PARITY (when PARITY≠0) or STOP. Otherwise increment index.
  - PARITY: tx = ^data for even, ~^data for odd. On tick go to STOP.
  - STOP: tx=1 for STOP_BITS×DIV cycles. On the final tick, if FIFO is non-empty, pop and go to START with no idle gap. Otherwise go to IDLE.
- Frame length is DIV×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- busy = (state≠IDLE) || (fifo_count≠0).
- Illegal parameter values are rejected at elaboration with $error.

## Timing
- Reset values: tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, FIFO pointers=0, baud counter=0.
- Reset asserted mid-frame: tx goes high asynchronously and the FIFO contents are discarded. After release, no partial frame resumes.
- Latency, pushing into an idle, empty block:
  - push edge at cycle 0
  - pop in IDLE at cycle 1
  - tx low from cycle 2
- fifo_count reflects a push/pop one cycle after the edge. A simultaneous push and pop leaves the count unchanged.
- A pop occurs only in IDLE or on the final STOP tick, never in any other state.
- The tx output register is updated on state entry, so line transitions are glitch-free and aligned to clk.
- FIFO pointers wrap modulo FIFO_DEPTH. full/empty are derived from the count, not from pointer equality alone.

## Structure
- Package uart_pkg holds:
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD
  - the FSM state enum
  - a function computing DIV from CLK_HZ and BAUD
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop, count, full and empty. The baud counter and FSM live in the top module.

## Test plan
Unless noted, use CLK_HZ=1_000_000 and BAUD=100_000, giving DIV=10.
- 8N1, push 0xA5 into an idle block:
  - tx low at cycle 2 for 10 cycles
  - then 1,0,1,0,0,1,0,1 at 10 cycles each
  - stop bit high
  - busy falls 100 cycles after tx first goes low
- 7E2, push 0x41: data bits 1,0,0,0,0,0,1, parity 0, two stop bits; frame is 110 cycles.
- 8O1, push 0x00: parity bit 1; push 0xFF: parity bit 1 (both are even-weight data, so odd parity is 1 for each).
- FIFO_DEPTH=4, hold in_valid for 8 cycles with data 1..8:
  - in_ready drops when fifo_count=4
  - exactly the accepted words appear in order
  - frames are back-to-back with no high gap beyond the stop bit
- Assert rst during data bit 3 of 0x5A with 2 words queued:
  - tx=1 and fifo_count=0 immediately, busy=0
  - after release, the line stays high with no output
- CLK_HZ=100_000_000, BAUD=9600: measured bit period is 10417 cycles and the start bit is exactly one period.
